// File: rtl/threedeeo_pad_reader.sv
// ---------------------------------------------------------------------------
// threedeeo_pad_reader
//
// Console-side initiator for the 3DO controller serial link. On a start
// request it sends a P/S latch pulse (ps high across one full clock period)
// to the pad. After a short gap it clocks FRAME_CLOCKS data periods. It
// samples the pad's serial data at the end of each high phase, and publishes
// the first NUM_BITS bits as one atomic word with a one-cycle valid strobe.
//
// Ports
//   system_clock  in   sole clock
//   reset_n       in   asynchronous active-low reset
//   start         in   single-cycle frame request, only honoured in IDLE
//   dat           in   serial data from the pad (asynchronous, synchronized)
//   clk           out  pad clock
//   ps            out  P/S latch line
//   buttons       out  last captured word, first bit shifted in at the MSB
//   valid         out  one-cycle pulse when buttons updates
//   busy          out  high from the cycle after start accept through DONE
// ---------------------------------------------------------------------------
module threedeeo_pad_reader #(
  parameter int HALF_CYCLES  = 260,
  parameter int GAP_CYCLES   = 2,
  parameter int FRAME_CLOCKS = 32,
  parameter int NUM_BITS     = 16
) (
  input  logic                system_clock,
  input  logic                reset_n,
  input  logic                start,
  input  logic                dat,
  output logic                clk,
  output logic                ps,
  output logic [NUM_BITS-1:0] buttons,
  output logic                valid,
  output logic                busy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAT_LO = 3'd1;
  localparam logic [2:0] S_LAT_HI = 3'd2;
  localparam logic [2:0] S_GAP    = 3'd3;
  localparam logic [2:0] S_BIT_LO = 3'd4;
  localparam logic [2:0] S_BIT_HI = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  // The phase counter only ever has to reach the longer of the two phase
  // lengths minus one.
  localparam int CNT_MAX = (HALF_CYCLES > GAP_CYCLES) ? HALF_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX);
  localparam int BW      = $clog2(FRAME_CLOCKS + 1);

  logic [2:0]          state, state_nxt;
  logic [CW-1:0]       cnt;
  logic [BW-1:0]       bit_idx;
  logic [NUM_BITS-1:0] shreg, shreg_nxt;
  logic                dat_meta, dat_sync;
  logic                half_last, gap_last, last_bit, keep_bit, sample;

  // -------------------------------------------------------------------------
  // Phase bookkeeping
  // -------------------------------------------------------------------------
  assign half_last = (cnt == CW'(HALF_CYCLES - 1));
  assign gap_last  = (cnt == CW'(GAP_CYCLES - 1));
  assign last_bit  = (bit_idx == BW'(FRAME_CLOCKS - 1));
  assign keep_bit  = (bit_idx < BW'(NUM_BITS));

  // Sample on the last cycle of the high phase. The pad changes data on the
  // rising edge, so this leaves the most settling time after the synchronizer.
  assign sample    = (state == S_BIT_HI) && half_last;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start)     state_nxt = S_LAT_LO;
      S_LAT_LO: if (half_last) state_nxt = S_LAT_HI;
      S_LAT_HI: if (half_last) state_nxt = S_GAP;
      S_GAP:    if (gap_last)  state_nxt = S_BIT_LO;
      S_BIT_LO: if (half_last) state_nxt = S_BIT_HI;
      S_BIT_HI: if (half_last) state_nxt = last_bit ? S_DONE : S_BIT_LO;
      S_DONE:                  state_nxt = S_IDLE;
      default:                 state_nxt = S_IDLE;
    endcase
  end

  // Bits past NUM_BITS (daisy-chain data) are clocked but not kept.
  always_comb begin
    shreg_nxt = shreg;
    if (sample && keep_bit)
      shreg_nxt = (shreg << 1) | NUM_BITS'(dat_sync);
  end

  // -------------------------------------------------------------------------
  // Input synchronizer
  // -------------------------------------------------------------------------
  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      dat_meta <= 1'b0;
      dat_sync <= 1'b0;
    end else begin
      dat_meta <= dat;
      dat_sync <= dat_meta;
    end
  end

  // -------------------------------------------------------------------------
  // State, counters, shift register
  // -------------------------------------------------------------------------
  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state <= state_nxt;

      // Restart the phase counter on every state change; hold it at zero
      // while idle so each frame starts from a known count.
      if ((state_nxt != state) || (state == S_IDLE))
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;

      if ((state == S_IDLE) && start) begin
        bit_idx <= '0;
        shreg   <= '0;
      end else begin
        shreg <= shreg_nxt;
        if (sample)
          bit_idx <= bit_idx + 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Registered outputs, decoded from the next state so they line up exactly
  // with the state they belong to and never glitch.
  // -------------------------------------------------------------------------
  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      clk     <= 1'b0;
      ps      <= 1'b0;
      busy    <= 1'b0;
      valid   <= 1'b0;
      buttons <= '0;
    end else begin
      clk   <= (state_nxt == S_LAT_HI) || (state_nxt == S_BIT_HI);
      ps    <= (state_nxt == S_LAT_LO) || (state_nxt == S_LAT_HI);
      busy  <= (state_nxt != S_IDLE);
      valid <= (state_nxt == S_DONE);
      // Load the post-shift value so the final sample is included even when
      // NUM_BITS equals FRAME_CLOCKS.
      if (state_nxt == S_DONE)
        buttons <= shreg_nxt;
    end
  end

endmodule

// File: tb/tb_threedeeo_pad_reader.sv
// ---------------------------------------------------------------------------
// Directed bench for threedeeo_pad_reader. It has a small instance
// (HALF_CYCLES=4) for the timing and control scenarios, and a
// default-parameter instance for the full-speed loopback. Each instance is
// driven by a behavioural pad that latches a 32-bit frame while ps is high
// and shifts out one bit on every data-clock rising edge.
// ---------------------------------------------------------------------------
module tb_threedeeo_pad_reader;

  localparam int H = 4;
  localparam int G = 2;
  localparam int F = 32;

  logic system_clock = 1'b0;
  logic reset_n      = 1'b0;
  always #5 system_clock = ~system_clock;

  // small instance
  logic        start_s = 1'b0;
  logic        dat_s   = 1'b0;
  logic        clk_s, ps_s, valid_s, busy_s;
  logic [15:0] buttons_s;
  logic [31:0] frame_s = 32'h0;
  int          idx_s   = 0;

  // default instance
  logic        start_d = 1'b0;
  logic        dat_d   = 1'b0;
  logic        clk_d, ps_d, valid_d, busy_d;
  logic [15:0] buttons_d;
  logic [31:0] frame_d = 32'h0;
  int          idx_d   = 0;

  int n_cmp = 0;
  int n_bad = 0;

  threedeeo_pad_reader #(.HALF_CYCLES(H), .GAP_CYCLES(G), .FRAME_CLOCKS(F), .NUM_BITS(16)) dut (
    .system_clock(system_clock), .reset_n(reset_n), .start(start_s), .dat(dat_s),
    .clk(clk_s), .ps(ps_s), .buttons(buttons_s), .valid(valid_s), .busy(busy_s)
  );

  threedeeo_pad_reader dut_def (
    .system_clock(system_clock), .reset_n(reset_n), .start(start_d), .dat(dat_d),
    .clk(clk_d), .ps(ps_d), .buttons(buttons_d), .valid(valid_d), .busy(busy_d)
  );

  // Behavioural pads: reset the bit pointer on the latch clock, otherwise
  // present the next frame bit on each data-clock rising edge.
  always @(posedge clk_s) begin
    if (ps_s) idx_s = 0;
    else begin
      if (idx_s < 32) dat_s = frame_s[31 - idx_s];
      idx_s++;
    end
  end

  always @(posedge clk_d) begin
    if (ps_d) idx_d = 0;
    else begin
      if (idx_d < 32) dat_d = frame_d[31 - idx_d];
      idx_d++;
    end
  end

  // Accept cycle ends at the edge after this; returns #1 after that edge.
  task automatic pulse_start_s();
    @(negedge system_clock);
    start_s = 1'b1;
    @(posedge system_clock); #1;
    start_s = 1'b0;
  endtask

  // Bounded wait for valid on the small instance.
  task automatic wait_valid_s(input int budget, output int cycles, output bit ok);
    cycles = 0;
    ok = 1'b0;
    while (cycles < budget) begin
      @(posedge system_clock); #1;
      cycles++;
      if (valid_s === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge system_clock);
    #1;
    n_cmp++;
    if ({clk_s, ps_s, valid_s, busy_s, buttons_s} !== 20'h0) begin
      n_bad++;
      $display("FAIL reset_small: got clk/ps/valid/busy/buttons=%h required 0",
               {clk_s, ps_s, valid_s, busy_s, buttons_s});
    end
    n_cmp++;
    if ({clk_d, ps_d, valid_d, busy_d, buttons_d} !== 20'h0) begin
      n_bad++;
      $display("FAIL reset_default: got clk/ps/valid/busy/buttons=%h required 0",
               {clk_d, ps_d, valid_d, busy_d, buttons_d});
    end
    @(negedge system_clock);
    reset_n = 1'b1;
    repeat (2) @(posedge system_clock);
  endtask

  task automatic test_reset_midframe();
    int  rises = 0;
    int  guard = 0;
    int  vcnt  = 0;
    int  bcnt  = 0;
    logic prev = 1'b0;
    frame_s = 32'hFFFF_FFFF;
    pulse_start_s();
    // Stop right after the 6th data-clock rise: BIT_HI of bit 5.
    while (rises < 6 && guard < 200) begin
      @(posedge system_clock); #1;
      guard++;
      if (clk_s && !prev && !ps_s) rises++;
      prev = clk_s;
    end
    n_cmp++;
    if (rises != 6 || clk_s !== 1'b1) begin
      n_bad++;
      $display("FAIL midframe_reach_bit5: got rises=%0d clk=%b required 6/1", rises, clk_s);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({clk_s, ps_s, busy_s, valid_s} !== 4'b0000) begin
      n_bad++;
      $display("FAIL midframe_reset_outputs: got clk/ps/busy/valid=%b required 0000",
               {clk_s, ps_s, busy_s, valid_s});
    end
    @(negedge system_clock);
    reset_n = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(posedge system_clock); #1;
      if (valid_s) vcnt++;
      if (busy_s) bcnt++;
    end
    n_cmp++;
    if (vcnt != 0 || bcnt != 0) begin
      n_bad++;
      $display("FAIL midframe_no_valid: got valid=%0d busy=%0d cycles required 0/0", vcnt, bcnt);
    end
    n_cmp++;
    if (buttons_s !== 16'h0000) begin
      n_bad++;
      $display("FAIL midframe_buttons: got %h required 0000", buttons_s);
    end
  endtask

  task automatic test_timing();
    bit   busy_hist [0:299];
    int   ps_cnt = 0, lh_cnt = 0, rises = 0, first_rise = -1, ps_fall = -1;
    int   hi_run = 0, lo_run = 0, bad_hi = 0, bad_lo = 0;
    int   valid_idx = -1, vcnt = 0;
    logic prev_clk = 1'b0, prev_ps = 1'b0, ps0;
    frame_s = 32'h0;
    pulse_start_s();
    ps0 = ps_s;
    for (int i = 0; i < 300; i++) begin
      busy_hist[i] = busy_s;
      if (ps_s) ps_cnt++;
      if (ps_s && clk_s) lh_cnt++;
      if (prev_ps && !ps_s && ps_fall < 0) ps_fall = i;
      if (!ps_s && clk_s && !prev_clk) begin
        rises++;
        if (first_rise < 0) first_rise = i;
        else if (lo_run != H) bad_lo++;
        lo_run = 0;
      end
      if (!ps_s && !prev_ps && prev_clk && !clk_s) begin
        if (hi_run != H) bad_hi++;
        hi_run = 0;
      end
      if (!ps_s && clk_s) hi_run++;
      if (!ps_s && !clk_s && busy_s && first_rise >= 0) lo_run++;
      if (valid_s) begin
        vcnt++;
        if (valid_idx < 0) valid_idx = i;
      end
      prev_clk = clk_s;
      prev_ps  = ps_s;
      @(posedge system_clock); #1;
    end
    n_cmp++;
    if (ps0 !== 1'b1 || ps_cnt != 2*H) begin
      n_bad++;
      $display("FAIL timing_ps_width: got first=%b cycles=%0d required 1/%0d", ps0, ps_cnt, 2*H);
    end
    n_cmp++;
    if (lh_cnt != H) begin
      n_bad++;
      $display("FAIL timing_latch_clock: got %0d high cycles required %0d", lh_cnt, H);
    end
    n_cmp++;
    if (first_rise - ps_fall != G + H) begin
      n_bad++;
      $display("FAIL timing_gap: got %0d cycles ps-fall to first clk rise required %0d",
               first_rise - ps_fall, G + H);
    end
    n_cmp++;
    if (rises != F) begin
      n_bad++;
      $display("FAIL timing_data_clocks: got %0d required %0d", rises, F);
    end
    n_cmp++;
    if (bad_hi != 0 || bad_lo != 0) begin
      n_bad++;
      $display("FAIL timing_half_periods: got bad_hi=%0d bad_lo=%0d required 0/0", bad_hi, bad_lo);
    end
    n_cmp++;
    if (valid_idx + 1 != 267 || vcnt != 1) begin
      n_bad++;
      $display("FAIL timing_latency: got %0d cycles (%0d pulses) required 267 (1)", valid_idx + 1, vcnt);
    end
    n_cmp++;
    if (valid_idx < 0 || valid_idx > 298 || busy_hist[valid_idx] !== 1'b1 ||
        busy_hist[valid_idx + 1] !== 1'b0) begin
      n_bad++;
      $display("FAIL timing_busy_fall: busy not high in DONE and low the next cycle (valid_idx=%0d)",
               valid_idx);
    end
  endtask

  task automatic test_loopback_default();
    int vidx = -1, vcnt = 0;
    logic [15:0] word = 16'h0;
    frame_d = {16'b1100000000000110, 16'h0000};
    @(negedge system_clock);
    start_d = 1'b1;
    @(posedge system_clock); #1;
    start_d = 1'b0;
    for (int i = 0; i < 17300; i++) begin
      if (valid_d) begin
        vcnt++;
        if (vidx < 0) begin
          vidx = i;
          word = buttons_d;
        end
      end
      @(posedge system_clock); #1;
    end
    n_cmp++;
    if (word !== 16'hC006) begin
      n_bad++;
      $display("FAIL loopback_buttons: got %h required c006", word);
    end
    n_cmp++;
    if (vcnt != 1 || vidx + 1 != 17163) begin
      n_bad++;
      $display("FAIL loopback_valid: got %0d pulses at %0d cycles required 1 at 17163", vcnt, vidx + 1);
    end
  endtask

  task automatic test_trailing();
    int cyc;
    bit ok;
    frame_s = 32'hFFFF_0000;
    pulse_start_s();
    wait_valid_s(400, cyc, ok);
    n_cmp++;
    if (ok !== 1'b1 || buttons_s !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL trailing_ones: got %h (ok=%b) required ffff", buttons_s, ok);
    end
    @(posedge system_clock); #1;
    frame_s = 32'h0000_FFFF;
    pulse_start_s();
    wait_valid_s(400, cyc, ok);
    n_cmp++;
    if (ok !== 1'b1 || buttons_s !== 16'h0000) begin
      n_bad++;
      $display("FAIL trailing_zeros: got %h (ok=%b) required 0000", buttons_s, ok);
    end
    @(posedge system_clock); #1;
  endtask

  task automatic test_start_handling();
    int cyc;
    bit ok;
    int bcnt = 0;
    frame_s = {16'h1234, 16'h0000};
    pulse_start_s();
    repeat (50) @(posedge system_clock);
    pulse_start_s();                      // while busy: must be dropped
    wait_valid_s(400, cyc, ok);
    n_cmp++;
    if (ok !== 1'b1 || cyc != 215 || buttons_s !== 16'h1234) begin
      n_bad++;
      $display("FAIL start_while_busy: got %0d cycles buttons=%h required 215/1234", cyc, buttons_s);
    end
    start_s = 1'b1;                       // sampled at the end of DONE
    @(posedge system_clock); #1;
    start_s = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (busy_s) bcnt++;
      @(posedge system_clock); #1;
    end
    n_cmp++;
    if (bcnt != 0) begin
      n_bad++;
      $display("FAIL start_in_done: got %0d busy cycles required 0", bcnt);
    end
    pulse_start_s();
    wait_valid_s(400, cyc, ok);
    @(posedge system_clock); #1;          // IDLE cycle after DONE
    start_s = 1'b1;
    @(posedge system_clock); #1;
    start_s = 1'b0;
    n_cmp++;
    if (ok !== 1'b1 || busy_s !== 1'b1 || ps_s !== 1'b1) begin
      n_bad++;
      $display("FAIL start_after_done: got busy=%b ps=%b ok=%b required 1/1/1", busy_s, ps_s, ok);
    end
    wait_valid_s(400, cyc, ok);
    n_cmp++;
    if (ok !== 1'b1) begin
      n_bad++;
      $display("FAIL start_after_done_frame: got no valid within 400 cycles required one");
    end
    @(posedge system_clock); #1;
  endtask

  task automatic test_back_to_back();
    int cyc = 0;
    bit ok = 1'b0;
    int hold_bad = 0;
    frame_s = {16'hA5A5, 16'h0000};
    pulse_start_s();
    wait_valid_s(400, cyc, ok);
    n_cmp++;
    if (ok !== 1'b1 || buttons_s !== 16'hA5A5) begin
      n_bad++;
      $display("FAIL b2b_first: got %h (ok=%b) required a5a5", buttons_s, ok);
    end
    frame_s = {16'h5A5A, 16'h0000};
    @(posedge system_clock); #1;
    start_s = 1'b1;
    @(posedge system_clock); #1;
    start_s = 1'b0;
    ok  = 1'b0;
    cyc = 0;
    while (cyc < 400) begin
      if (valid_s) begin
        ok = 1'b1;
        break;
      end
      if (buttons_s !== 16'hA5A5) hold_bad++;
      @(posedge system_clock); #1;
      cyc++;
    end
    n_cmp++;
    if (hold_bad != 0) begin
      n_bad++;
      $display("FAIL b2b_hold: got %0d cycles with buttons != a5a5 required 0", hold_bad);
    end
    n_cmp++;
    if (ok !== 1'b1 || buttons_s !== 16'h5A5A) begin
      n_bad++;
      $display("FAIL b2b_second: got %h (ok=%b) required 5a5a", buttons_s, ok);
    end
  endtask

  initial begin
    test_reset();
    test_reset_midframe();
    test_timing();
    test_trailing();
    test_start_handling();
    test_back_to_back();
    test_loopback_default();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/threedeeo_pad_reader.md
Name: threedeeo_pad_reader

Overview:
- Console-side initiator for the 3DO controller serial link; the other end of the pad-emulation path.
- On request, it drives the pad clock and P/S latch line and shifts in the pad's serial data line.
- It publishes the captured 16-bit button word atomically, with a one-cycle valid strobe.
- Used for bench loopback against the pad emulator and for reading a real 3DO pad into the adapter core.

Parameters:
- HALF_CYCLES, 260, system_clock cycles per pad-clock half period (13 us at 20 MHz); minimum 4.
- GAP_CYCLES, 2, system_clock cycles with ps low and pad clock low between the latch pulse and the first data clock; minimum 1.
- FRAME_CLOCKS, 32, data clock periods per frame, daisy-chain bits included.
- NUM_BITS, 16, number of leading bits captured into buttons; must be at most FRAME_CLOCKS.

Ports:
- system_clock  in  1  sole clock for all logic.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle frame request; ignored while busy=1.
- dat  in  1  serial data from the pad; asynchronous; passes through a 2-flop synchronizer before use.
- clk  out  1  pad clock to the controller.
- ps  out  1  P/S latch line to the controller.
- buttons  out  NUM_BITS  last captured word; the first bit shifted in lands in the MSB.
- valid  out  1  one-cycle pulse when buttons is updated.
- busy  out  1  high from the cycle after start is accepted through the DONE cycle.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; clk=0, ps=0, buttons=0, valid=0, busy=0; half/bit counters and shift register cleared. Reset asserted mid-frame aborts the frame; no valid pulse is produced.
- All outputs are registered and glitch-free.
- States and transitions:
  - IDLE: clk=0, ps=0. start=1 moves to LAT_LO on the next edge.
  - LAT_LO: ps=1, clk=0 for HALF_CYCLES, then LAT_HI.
  - LAT_HI: ps=1, clk=1 for HALF_CYCLES, then GAP. This is the latch clock; nothing is sampled.
  - GAP: ps=0, clk=0 for GAP_CYCLES, then BIT_LO.
  - BIT_LO: clk=0 for HALF_CYCLES, then BIT_HI.
  - BIT_HI: clk=1 for HALF_CYCLES. On the last cycle of the phase, synchronized dat is sampled.
    - While bit index < NUM_BITS, the sample shifts into the shift register LSB (shift left). Later bits are discarded.
    - Bit index then increments. If index reaches FRAME_CLOCKS, go to DONE; otherwise go to BIT_LO.
  - DONE (1 cycle): buttons <= shift register; valid=1; busy=1. Next state is IDLE.
- Latency: valid asserts 2*HALF_CYCLES + GAP_CYCLES + 2*HALF_CYCLES*FRAME_CLOCKS + 1 cycles after the start-accept cycle. With defaults this is 520+2+16640+1 = 17163.
- start during busy is dropped, not queued. start in the DONE cycle is also dropped. start in the cycle where busy falls (IDLE) is accepted.
- buttons holds its value between frames and never shows a partial word.
- Bit order: the first data bit becomes buttons[NUM_BITS-1] and the NUM_BITS-th bit becomes buttons[0].
- Sampling at the end of the high phase gives at least HALF_CYCLES-2 cycles of margin after synchronization for data the pad changes on the clk rising edge.

Test Plan:
- Reset mid-frame: assert reset_n=0 during BIT_HI of bit 5 -> clk=0, ps=0, busy=0 at once; no valid; buttons keeps its reset value 0.
- Timing (HALF_CYCLES=4, GAP_CYCLES=2, FRAME_CLOCKS=32): pulse start -> ps high for exactly 8 cycles with one clk pulse of 4 cycles; 32 data clk pulses of 4 cycles high / 4 low; valid exactly 267 cycles after start accept; busy low on the next cycle.
- Loopback with the pad emulator loaded with i=16'b1100000000000110, at default parameters -> buttons=16'hC006; valid pulses once per frame.
- Trailing bits: drive dat=1 for bits 0-15 and dat=0 for bits 16-31 -> buttons=16'hFFFF; then the inverse pattern -> buttons=16'h0000, showing bits beyond NUM_BITS are discarded.
- start handling: pulse start again while busy and in the DONE cycle -> no extra frame; start in the cycle after DONE -> a second frame starts immediately.
- Back-to-back frames with different pad words 16'hA5A5 then 16'h5A5A -> buttons holds 16'hA5A5 unchanged throughout frame 2 until frame 2's DONE cycle, then becomes 16'h5A5A.
